// File: rtl/one_to_n_stream_demux.sv
// One-to-N stream demultiplexer: routes a valid/ready word to one registered channel, or to all in broadcast.
// Define DEMUX_CNT_EN to add per-channel 16-bit handshake counters on output cnt.
module one_to_n_stream_demux #(
   parameter int  WIDTH = 8,
   parameter int  N     = 4,
   localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   din,
   input  logic               din_valid,
   output logic               din_ready,
   input  logic [SELW-1:0]    sel,
   input  logic               bcast,
   output logic [N*WIDTH-1:0] dout,
   output logic [N-1:0]       dout_valid,
   input  logic [N-1:0]       dout_ready,
   output logic               err_sel
`ifdef DEMUX_CNT_EN
   ,
   output logic [N*16-1:0]    cnt
`endif
);

   localparam logic [SELW:0] NUM_CH = (SELW+1)'(N);

   logic [N-1:0] free;
   logic [N-1:0] hit;
   logic [N-1:0] load;
   logic         sel_ok;
   logic         accept;
   logic         err_sel_reg;

   assign sel_ok = ({1'b0, sel} < NUM_CH);
   assign accept = din_valid && din_ready;

   // Out-of-range selects are sunk so a bad address can never stall the producer.
   always_comb begin
      din_ready = 1'b1;
      if (bcast) begin
         din_ready = &free;
      end else if (sel_ok) begin
         din_ready = |(hit & free);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_ch
         localparam logic [SELW-1:0] CH_IDX = SELW'(gi);

         logic [WIDTH-1:0] data_reg;
         logic             valid_reg;

         assign hit[gi]  = (sel == CH_IDX);
         assign free[gi] = !valid_reg || dout_ready[gi];
         assign load[gi] = accept && (bcast || hit[gi]);

         // A load wins over a drain, giving same-cycle refill without a bubble.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_reg  <= '0;
               valid_reg <= 1'b0;
            end else if (load[gi]) begin
               data_reg  <= din;
               valid_reg <= 1'b1;
            end else if (dout_ready[gi]) begin
               valid_reg <= 1'b0;
            end
         end

         assign dout[gi*WIDTH +: WIDTH] = data_reg;
         assign dout_valid[gi]          = valid_reg;

`ifdef DEMUX_CNT_EN
         logic [15:0] cnt_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg <= '0;
            end else if (valid_reg && dout_ready[gi]) begin
               cnt_reg <= cnt_reg + 16'd1;
            end
         end

         assign cnt[gi*16 +: 16] = cnt_reg;
`endif
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sel_reg <= 1'b0;
      end else if (accept && !bcast && !sel_ok) begin
         err_sel_reg <= 1'b1;
      end
   end

   assign err_sel = err_sel_reg;

endmodule

// File: tb/tb_one_to_n_stream_demux.sv
// Bench for one_to_n_stream_demux: N=4 and N=3 instances share one stimulus stream and a behavioural model.
module tb_one_to_n_stream_demux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  din;
   logic        din_valid;
   logic        bcast;
   logic [1:0]  sel;
   logic [3:0]  dout_ready;

   logic        din_ready4, din_ready3, err4, err3;
   logic [31:0] dout4;
   logic [23:0] dout3;
   logic [3:0]  dout_valid4;
   logic [2:0]  dout_valid3;
`ifdef DEMUX_CNT_EN
   logic [63:0] cnt4;
   logic [47:0] cnt3;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   one_to_n_stream_demux #(.WIDTH(8), .N(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready4),
      .sel(sel), .bcast(bcast), .dout(dout4), .dout_valid(dout_valid4),
      .dout_ready(dout_ready), .err_sel(err4)
`ifdef DEMUX_CNT_EN
      , .cnt(cnt4)
`endif
   );

   one_to_n_stream_demux #(.WIDTH(8), .N(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready3),
      .sel(sel), .bcast(bcast), .dout(dout3), .dout_valid(dout_valid3),
      .dout_ready(dout_ready[2:0]), .err_sel(err3)
`ifdef DEMUX_CNT_EN
      , .cnt(cnt3)
`endif
   );

   // Behavioural model: index 0 is the N=4 instance, index 1 the N=3 instance.
   int          nch [2] = '{4, 3};
   logic [7:0]  m_data  [2][4];
   logic        m_valid [2][4];
   logic [15:0] m_cnt   [2][4];
   logic        m_err   [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_ready(input int m);
      logic r;
      if (bcast) begin
         r = 1'b1;
         for (int k = 0; k < nch[m]; k++) r = r && (!m_valid[m][k] || dout_ready[k]);
      end else if (int'(sel) < nch[m]) begin
         r = !m_valid[m][int'(sel)] || dout_ready[int'(sel)];
      end else begin
         r = 1'b1;
      end
      return r;
   endfunction

   task automatic m_clear();
      for (int m = 0; m < 2; m++) begin
         m_err[m] = 1'b0;
         for (int k = 0; k < 4; k++) begin
            m_data[m][k] = 8'h00; m_valid[m][k] = 1'b0; m_cnt[m][k] = 16'h0000;
         end
      end
   endtask

   initial begin
      m_clear();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_clear();
         end else begin
            for (int m = 0; m < 2; m++) begin
               logic acc;
               acc = din_valid && m_ready(m);
               for (int k = 0; k < nch[m]; k++) begin
                  if (m_valid[m][k] && dout_ready[k]) m_cnt[m][k] = m_cnt[m][k] + 16'd1;
                  if (acc && (bcast || int'(sel) == k)) begin
                     m_data[m][k]  = din;
                     m_valid[m][k] = 1'b1;
                  end else if (dout_ready[k]) begin
                     m_valid[m][k] = 1'b0;
                  end
               end
               if (acc && !bcast && int'(sel) >= nch[m]) m_err[m] = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial begin
      logic [31:0] ed;
      logic [3:0]  ev;
      logic [63:0] ec;
      forever begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            ed = '0; ev = '0; ec = '0;
            for (int k = 0; k < nch[m]; k++) begin
               ed[k*8 +: 8]   = m_data[m][k];
               ev[k]          = m_valid[m][k];
               ec[k*16 +: 16] = m_cnt[m][k];
            end
            if (m == 0) begin
               chk("n4 dout_valid", 64'(dout_valid4), 64'(ev));
               chk("n4 dout", 64'(dout4), 64'(ed));
               chk("n4 din_ready", 64'(din_ready4), 64'(m_ready(0)));
               chk("n4 err_sel", 64'(err4), 64'(m_err[0]));
`ifdef DEMUX_CNT_EN
               chk("n4 cnt", cnt4, ec);
`endif
            end else begin
               chk("n3 dout_valid", 64'(dout_valid3), 64'(ev));
               chk("n3 dout", 64'(dout3), 64'(ed));
               chk("n3 din_ready", 64'(din_ready3), 64'(m_ready(1)));
               chk("n3 err_sel", 64'(err3), 64'(m_err[1]));
`ifdef DEMUX_CNT_EN
               chk("n3 cnt", 64'(cnt3), ec);
`endif
            end
         end
      end
   end

   // Producer rule: a stalled offer must hold its word and routing.
   initial begin
      logic       p_stall;
      logic [7:0] p_din;
      logic [1:0] p_sel;
      logic       p_bcast;
      p_stall = 1'b0; p_din = '0; p_sel = '0; p_bcast = 1'b0;
      forever begin
         @(posedge clk);
         if (rst_n === 1'b1 && p_stall)
            assert (din == p_din && sel == p_sel && bcast == p_bcast)
               else $error("producer changed a stalled word");
         p_stall = (rst_n === 1'b1) && din_valid && !din_ready4;
         p_din = din; p_sel = sel; p_bcast = bcast;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic stalled;
      rst_n = 1'b0; din = 8'hEE; din_valid = 1'b1; sel = 2'd1; bcast = 1'b0; dout_ready = 4'b0000;

      $display("reset held with din_valid=1");
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("reset dout_valid", 64'(dout_valid4), 64'h0);
         chk("reset dout", 64'(dout4), 64'h0);
         chk("reset err_sel", 64'(err3), 64'h0);
      end
      rst_n = 1'b1;
      tick();
      $display("first accept after reset: EE -> ch1");
      chk("first accept valid", 64'(dout_valid4), 64'h2);
      chk("first accept data", 64'(dout4[15:8]), 64'hEE);
      din_valid = 1'b0; dout_ready = 4'b1111;
      tick();

      $display("addressed: A5 -> ch2, 3C -> ch0");
      din = 8'hA5; sel = 2'd2; din_valid = 1'b1;
      tick();
      chk("addr A5 valid", 64'(dout_valid4), 64'h4);
      chk("addr A5 data", 64'(dout4[23:16]), 64'hA5);
      din = 8'h3C; sel = 2'd0;
      tick();
      chk("addr 3C valid", 64'(dout_valid4), 64'h1);
      chk("addr 3C data", 64'(dout4[7:0]), 64'h3C);
      din_valid = 1'b0;
      tick();

      $display("back-pressure: ch0 holds 11, 22 -> ch1");
      dout_ready = 4'b1110; din = 8'h11; sel = 2'd0; din_valid = 1'b1;
      tick();
      chk("bp ch0 loaded", 64'(dout4[7:0]), 64'h11);
      din_valid = 1'b0;
      #1 chk("bp din_ready sel0", 64'(din_ready4), 64'h0);
      tick(); tick();
      chk("bp ch0 held valid", 64'(dout_valid4), 64'h1);
      chk("bp ch0 held data", 64'(dout4[7:0]), 64'h11);
      din = 8'h22; sel = 2'd1; din_valid = 1'b1;
      #1 chk("bp din_ready sel1", 64'(din_ready4), 64'h1);
      tick();
      chk("bp ch1 valid", 64'(dout_valid4), 64'h3);
      chk("bp ch1 data", 64'(dout4[15:0]), 64'h2211);
      din_valid = 1'b0; dout_ready = 4'b1111;
      tick();

      $display("broadcast: 5A blocked by ch3, then all channels");
      dout_ready = 4'b0111; din = 8'h33; sel = 2'd3; din_valid = 1'b1;
      tick();
      chk("bc ch3 setup", 64'(dout_valid4), 64'h8);
      din = 8'h5A; bcast = 1'b1;
      #1 chk("bc din_ready blocked", 64'(din_ready4), 64'h0);
      tick();
      chk("bc no change valid", 64'(dout_valid4), 64'h8);
      chk("bc no change data", 64'(dout4), 64'h33A52211);
      dout_ready = 4'b1111;
      #1 chk("bc din_ready open", 64'(din_ready4), 64'h1);
      tick();
      chk("bc all valid", 64'(dout_valid4), 64'hF);
      chk("bc all data", 64'(dout4), 64'h5A5A5A5A);
      din_valid = 1'b0; bcast = 1'b0;
      tick();

      $display("invalid select on N=3: FF -> sel 3");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1 chk("inv err before", 64'(err3), 64'h0);
      din = 8'hFF; sel = 2'd3; din_valid = 1'b1;
      #1 chk("inv din_ready", 64'(din_ready3), 64'h1);
      tick();
      chk("inv err set", 64'(err3), 64'h1);
      chk("inv no valid", 64'(dout_valid3), 64'h0);
      din_valid = 1'b0;
      tick(); tick();
      chk("inv err sticky", 64'(err3), 64'h1);

`ifdef DEMUX_CNT_EN
      $display("counter stream: 70000 words -> ch1");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; sel = 2'd1; din_valid = 1'b1; dout_ready = 4'b1111;
      for (int i = 0; i < 70000; i++) begin
         din = 8'($urandom);
         tick();
      end
      din_valid = 1'b0;
      tick(); tick();
      chk("cnt4 ch1 wrap", 64'(cnt4[31:16]), 64'd4464);
      chk("cnt3 ch1 wrap", 64'(cnt3[31:16]), 64'd4464);
`endif

      $display("async reset pulse between edges");
      dout_ready = 4'b0000; din = 8'h6B; sel = 2'd0; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async dout_valid4", 64'(dout_valid4), 64'h0);
      chk("async dout_valid3", 64'(dout_valid3), 64'h0);
      chk("async err3", 64'(err3), 64'h0);
`ifdef DEMUX_CNT_EN
      chk("async cnt4", cnt4, 64'h0);
`endif
      #1 rst_n = 1'b1;

      $display("random traffic");
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         stalled = din_valid && !din_ready4;
         tick();
         if (!stalled) begin
            din       = 8'($urandom);
            sel       = 2'($urandom);
            bcast     = ($urandom_range(0, 7) == 0);
            din_valid = ($urandom_range(0, 3) != 0);
         end
         dout_ready = 4'($urandom);
      end
      din_valid = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/one_to_n_stream_demux.md
Name: one_to_n_stream_demux

Overview:
- Parametrised successor of the 1-to-2 demultiplexer.
- Routes a WIDTH-bit input stream to one of N output channels, selected by sel, or to all channels when bcast is high.
- Each channel has a one-entry output register with a valid/ready handshake, so a stalled consumer back-pressures only its own traffic.
- Sits between a single producer and N independent consumers in the combinational-circuits library's stream path.

Parameters:
WIDTH, 8, data width of din and of each output channel
N, 4, number of output channels (2..16; non-power-of-two allowed)
SELW (localparam), $clog2(N) (minimum 1), width of sel

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  WIDTH  input data word
din_valid  input  1  producer offers din
din_ready  output  1  demux accepts din this cycle
sel  input  SELW  destination channel index (ignored when bcast=1)
bcast  input  1  deliver the word to all N channels
dout  output  N*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH]
dout_valid  output  N  per-channel data valid
dout_ready  input  N  per-channel consumer ready
err_sel  output  1  sticky flag: a word was addressed to sel >= N

Behaviour:
- Reset:
  - Asserting rst_n=0 clears all channel data, dout_valid, and err_sel to 0 immediately, without waiting for clk.
  - Words in flight are discarded.
  - din_ready is combinational and may be high during reset, but nothing is captured while rst_n=0.
- Channel slot k:
  - free(k) = !dout_valid[k] || dout_ready[k].
  - Equivalently, a slot can be refilled in the same cycle it drains.
- din_ready (combinational):
  - bcast=1: AND of free(k) over all k.
  - bcast=0 and sel<N: free(sel).
  - bcast=0 and sel>=N: 1 (the word is sunk).
- Accept: din_valid && din_ready at a rising edge of clk.
- On accept, addressed mode, valid sel: channel sel loads din and sets dout_valid[sel]=1. Other channels are unaffected.
- On accept, broadcast: every channel loads din and sets dout_valid=1. Broadcast is atomic: all channels are written or none.
- On accept with sel>=N: no channel is written, and err_sel is set to 1. err_sel stays at 1 until reset.
- Without accept: any channel with dout_valid[k] && dout_ready[k] clears dout_valid[k]. Its dout data holds its last value.
- Latency: exactly 1 clk from accept to dout_valid. Sustained throughput is 1 word/clk per channel while the consumer holds ready high.
- Simultaneous drain and refill of the same channel: the new word is registered and dout_valid stays 1. No bubble and no loss.
- Producer rule: while din_valid=1 && din_ready=0, the producer holds din, sel, and bcast stable. Verification checks this with an assertion on the bench side.
- Consumer rule: dout_valid[k] and dout data are stable until the handshake completes.
- Output independence: dout_ready[k]=0 never affects acceptance for channels other than k, except in broadcast mode.
- Combinational paths: dout_ready → din_ready is an allowed combinational path. There is no path from din to dout.
- There is no internal FSM beyond the N slot-valid bits and err_sel.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- When defined:
  - Adds output port cnt, N*16 bits; channel k occupies [k*16 +: 16].
  - Each counter increments on dout_valid[k] && dout_ready[k].
  - Counters wrap from 65535 to 0 and reset to 0 on rst_n=0.
- When undefined: the cnt port and all counter logic are absent. Behaviour is otherwise identical.

Test Plan (all with N=4, WIDTH=8):
- Reset: hold rst_n=0 and drive din_valid=1 → dout_valid=4'b0000, dout=0, and err_sel=0 throughout. Release rst_n; the first accept occurs on the next edge.
- Addressed routing: all dout_ready=1; send 8'hA5 with sel=2, then 8'h3C with sel=0 on back-to-back clocks → required outputs:
  - dout_valid[2]=1 with data A5 one cycle after the first accept.
  - dout_valid[0]=1 with data 3C one cycle after the second accept.
  - No other channel goes valid.
- Back-pressure isolation: dout_ready=4'b1110 with channel 0 holding 8'h11:
  - sel=0 → din_ready=0, and channel 0 holds 11 until dout_ready[0]=1.
  - sel=1 with 8'h22 → accepted, and 22 appears on channel 1 next cycle.
- Broadcast atomicity: dout_ready=4'b0111, channel 3 valid, send 8'h5A with bcast=1:
  - din_ready=0, and no channel changes.
  - Raise dout_ready[3] → word accepted, and all four channels show 5A next cycle.
- Invalid select (N=3 build): send 8'hFF with sel=3 → din_ready=1, no dout_valid rises, and err_sel=1 from the next edge onward until rst_n=0.
- Async reset mid-stream, with DEMUX_CNT_EN defined:
  - Stream 70000 words to channel 1 with ready held high → cnt[1] wraps to 70000-65536=4464.
  - Pulse rst_n=0 between clk edges → dout_valid and cnt clear immediately.
